// File: rtl/md5_if.sv
`timescale 1ns/1ps
// md5_if: serial-link bundle between the MD5 search block and its host.
//   rxd        host -> block UART line (idle high)
//   txd        block -> host UART line (idle high)
//   match_led  match latch indicator
//   led        parser state code
interface md5_if #(
  parameter int NUM_LEDS = 4
);
  logic                rxd;
  logic                txd;
  logic                match_led;
  logic [NUM_LEDS-1:0] led;

  modport master (output rxd, input txd, input match_led, input led);
  modport slave  (input rxd, output txd, output match_led, output led);
endinterface

// File: rtl/md5_top.sv
`timescale 1ns/1ps
// md5_top: UART-controlled MD5 window search. The host loads a 128-bit target
// digest, then streams text; every 19-byte window is hashed and the first
// window whose digest equals the target is latched and can be read back.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-low
//   bus    md5_if.slave: rxd in; txd, match_led, led out
module md5_top #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD          = 12_000_000,
  parameter int NUM_LEDS      = 4
) (
  input logic  clk,
  input logic  reset,
  md5_if.slave bus
);
  localparam int BIT_CLKS  = (CLK_FREQUENCY + BAUD / 2) / BAUD;
  localparam int HALF_CLKS = BIT_CLKS / 2;
  localparam int CW        = $clog2(BIT_CLKS + 1);

  localparam logic [3:0] ST_IDLE = 4'd0, ST_HASH_RX = 4'd1, ST_LEN_HI = 4'd2,
                         ST_LEN_LO = 4'd3, ST_TEXT_RX = 4'd4, ST_TEXT_DRAIN = 4'd5,
                         ST_ACK_TX = 4'd6, ST_MATCH_TX = 4'd7, ST_TEST_TX = 4'd8;
  localparam logic [1:0] RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3;
  localparam logic [31:0] A0 = 32'h67452301, B0 = 32'hefcdab89,
                          C0 = 32'h98badcfe, D0 = 32'h10325476;

  // Sine-derived additive constant, four per table row.
  function automatic logic [31:0] k_const(input logic [5:0] i);
    logic [127:0] q;
    case (i[5:2])
      4'd0:  q = {32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee};
      4'd1:  q = {32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501};
      4'd2:  q = {32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be};
      4'd3:  q = {32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821};
      4'd4:  q = {32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa};
      4'd5:  q = {32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8};
      4'd6:  q = {32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed};
      4'd7:  q = {32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a};
      4'd8:  q = {32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c};
      4'd9:  q = {32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70};
      4'd10: q = {32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05};
      4'd11: q = {32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665};
      4'd12: q = {32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039};
      4'd13: q = {32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1};
      4'd14: q = {32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1};
      4'd15: q = {32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391};
      default: q = 128'd0;
    endcase
    return 32'(q >> (8'd96 - {1'b0, i[1:0], 5'd0}));
  endfunction

  // Per-round rotate amount: depends on the round group and round mod 4.
  function automatic logic [4:0] shift_amt(input logic [5:0] i);
    case ({i[5:4], i[1:0]})
      4'h0: return 5'd7;   4'h1: return 5'd12;  4'h2: return 5'd17;  4'h3: return 5'd22;
      4'h4: return 5'd5;   4'h5: return 5'd9;   4'h6: return 5'd14;  4'h7: return 5'd20;
      4'h8: return 5'd4;   4'h9: return 5'd11;  4'ha: return 5'd16;  4'hb: return 5'd23;
      4'hc: return 5'd6;   4'hd: return 5'd10;  4'he: return 5'd15;  4'hf: return 5'd21;
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
    return 32'({x, x} >> (6'd32 - {1'b0, s}));
  endfunction

  // Digest words are little-endian, so the hex digest needs a byte swap.
  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  logic [3:0]    state_r, hash_cnt_r;
  logic [4:0]    out_idx_r;
  logic [7:0]    ack_r, rx_sh_r, tx_data_s, win_byte_s;
  logic [15:0]   len_r, index_r, match_pos_r;
  logic [127:0]  target_r, digest_s;
  logic [151:0]  window_r, match_win_r;
  logic          match_r, rx_meta_r, rx_sync_r, rx_valid_r;
  logic [1:0]    rx_st_r;
  logic [2:0]    rx_bit_r;
  logic [CW-1:0] rx_cnt_r, tx_cnt_r;
  logic [8:0]    tx_sh_r;
  logic [3:0]    tx_bits_r;
  logic          tx_busy_r, txd_r, tx_valid_s, tx_ready_s, tx_load_s;
  logic          md5_busy_r, md5_done_r, md5_start_s;
  logic [5:0]    round_r;
  logic [31:0]   a_r, b_r, c_r, d_r, f_s, tmp_s, new_b_s;
  logic [3:0]    g_s;
  logic [511:0]  block_s;

  // Input synchronizer and 8N1 receiver with mid-bit sampling.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta_r <= 1'b1; rx_sync_r <= 1'b1; rx_st_r <= RX_IDLE; rx_cnt_r <= '0;
      rx_bit_r <= 3'd0; rx_sh_r <= 8'd0; rx_valid_r <= 1'b0;
    end else begin
      rx_meta_r  <= bus.rxd;
      rx_sync_r  <= rx_meta_r;
      rx_valid_r <= 1'b0;
      case (rx_st_r)
        RX_IDLE: if (!rx_sync_r) begin rx_cnt_r <= '0; rx_st_r <= RX_START; end
        RX_START:
          if (rx_cnt_r == CW'(HALF_CLKS - 1)) begin
            rx_cnt_r <= '0; rx_bit_r <= 3'd0;
            rx_st_r  <= rx_sync_r ? RX_IDLE : RX_DATA;   // glitch, not a start bit
          end else rx_cnt_r <= rx_cnt_r + CW'(1);
        RX_DATA:
          if (rx_cnt_r == CW'(BIT_CLKS - 1)) begin
            rx_cnt_r <= '0;
            rx_sh_r  <= {rx_sync_r, rx_sh_r[7:1]};
            rx_bit_r <= rx_bit_r + 3'd1;
            if (rx_bit_r == 3'd7) rx_st_r <= RX_STOP;
          end else rx_cnt_r <= rx_cnt_r + CW'(1);
        RX_STOP:
          if (rx_cnt_r == CW'(BIT_CLKS - 1)) begin
            rx_valid_r <= rx_sync_r;                     // framing error drops the byte
            rx_st_r    <= RX_IDLE;
          end else rx_cnt_r <= rx_cnt_r + CW'(1);
        default: rx_st_r <= RX_IDLE;
      endcase
    end
  end

  // Transmitter accepts the next byte on the last clock of a stop bit so
  // consecutive response bytes leave with no idle gap.
  assign tx_ready_s = !tx_busy_r || (tx_bits_r == 4'd9 && tx_cnt_r == CW'(BIT_CLKS - 1));
  assign tx_load_s  = tx_ready_s && tx_valid_s;

  // 8N1 transmit shifter; txd is driven straight from a flop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      txd_r <= 1'b1; tx_busy_r <= 1'b0; tx_sh_r <= 9'h1ff; tx_bits_r <= 4'd0; tx_cnt_r <= '0;
    end else if (tx_load_s) begin
      txd_r <= 1'b0; tx_sh_r <= {1'b1, tx_data_s}; tx_bits_r <= 4'd0;
      tx_cnt_r <= '0; tx_busy_r <= 1'b1;
    end else if (tx_busy_r) begin
      if (tx_cnt_r == CW'(BIT_CLKS - 1)) begin
        tx_cnt_r <= '0;
        if (tx_bits_r == 4'd9) begin
          tx_busy_r <= 1'b0; txd_r <= 1'b1;
        end else begin
          txd_r <= tx_sh_r[0]; tx_sh_r <= {1'b1, tx_sh_r[8:1]}; tx_bits_r <= tx_bits_r + 4'd1;
        end
      end else tx_cnt_r <= tx_cnt_r + CW'(1);
    end
  end

  // Padded single block: 19 message bytes, 0x80, zeros, bit length 152.
  always_comb begin
    block_s = '0;
    for (int k = 0; k < 19; k++) block_s[8*k +: 8] = window_r[151-8*k -: 8];
    block_s[159:152] = 8'h80;
    block_s[455:448] = 8'h98;
  end

  // One MD5 round of combinational logic.
  always_comb begin
    f_s = 32'd0;
    g_s = 4'd0;
    case (round_r[5:4])
      2'd0: begin f_s = (b_r & c_r) | (~b_r & d_r); g_s = round_r[3:0]; end
      2'd1: begin f_s = (d_r & b_r) | (~d_r & c_r); g_s = round_r[3:0] * 4'd5 + 4'd1; end
      2'd2: begin f_s = b_r ^ c_r ^ d_r;            g_s = round_r[3:0] * 4'd3 + 4'd5; end
      2'd3: begin f_s = c_r ^ (b_r | ~d_r);         g_s = round_r[3:0] * 4'd7; end
      default: begin f_s = 32'd0; g_s = 4'd0; end
    endcase
    tmp_s    = a_r + f_s + k_const(round_r) + block_s[{g_s, 5'd0} +: 32];
    new_b_s  = b_r + rotl(tmp_s, shift_amt(round_r));
    digest_s = {bswap(a_r + A0), bswap(b_r + B0), bswap(c_r + C0), bswap(d_r + D0)};
  end

  assign md5_start_s = rx_valid_r && (state_r == ST_TEXT_RX) && (index_r >= 16'd18);

  // Iterative MD5 engine: one round per clock, done pulses after round 63.
  always_ff @(posedge clk) begin
    if (!reset) begin
      md5_busy_r <= 1'b0; md5_done_r <= 1'b0; round_r <= 6'd0;
      a_r <= 32'd0; b_r <= 32'd0; c_r <= 32'd0; d_r <= 32'd0;
    end else begin
      md5_done_r <= 1'b0;
      if (md5_start_s) begin
        a_r <= A0; b_r <= B0; c_r <= C0; d_r <= D0; round_r <= 6'd0; md5_busy_r <= 1'b1;
      end else if (md5_busy_r) begin
        a_r <= d_r; d_r <= c_r; c_r <= b_r; b_r <= new_b_s;
        round_r <= round_r + 6'd1;
        if (round_r == 6'd63) begin md5_busy_r <= 1'b0; md5_done_r <= 1'b1; end
      end
    end
  end

  // Response byte source for the transmitter.
  always_comb begin
    tx_valid_s = 1'b0;
    tx_data_s  = 8'd0;
    win_byte_s = 8'(match_win_r >> (8'd144 - {out_idx_r - 5'd2, 3'b000}));
    case (state_r)
      ST_ACK_TX: begin tx_valid_s = 1'b1; tx_data_s = ack_r; end
      ST_MATCH_TX: begin
        tx_valid_s = 1'b1;
        if (!match_r)               tx_data_s = 8'd0;
        else if (out_idx_r == 5'd0) tx_data_s = match_pos_r[15:8];
        else if (out_idx_r == 5'd1) tx_data_s = match_pos_r[7:0];
        else                        tx_data_s = win_byte_s;
      end
      ST_TEST_TX: begin tx_valid_s = 1'b1; tx_data_s = 8'd5 - {3'd0, out_idx_r}; end
      default: begin tx_valid_s = 1'b0; tx_data_s = 8'd0; end
    endcase
  end

  // Command parser, match latch and text window.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE; hash_cnt_r <= 4'd0; out_idx_r <= 5'd0; ack_r <= 8'd0;
      len_r <= 16'd0; index_r <= 16'd0; match_pos_r <= 16'd0; target_r <= 128'd0;
      window_r <= 152'd0; match_win_r <= 152'd0; match_r <= 1'b0;
    end else begin
      if (md5_done_r && !match_r && digest_s == target_r) begin
        match_r     <= 1'b1;
        match_pos_r <= index_r - 16'd1;          // index already advanced past last byte
        match_win_r <= window_r;
      end
      if (tx_load_s) out_idx_r <= out_idx_r + 5'd1;
      case (state_r)
        ST_IDLE:
          if (rx_valid_r) begin
            out_idx_r <= 5'd0;
            hash_cnt_r <= 4'd0;
            case (rx_sh_r)
              8'h01:   state_r <= ST_HASH_RX;
              8'h02:   state_r <= ST_LEN_HI;
              8'h03:   state_r <= ST_MATCH_TX;
              8'h04:   state_r <= ST_TEST_TX;
              default: state_r <= ST_IDLE;
            endcase
          end
        ST_HASH_RX:
          if (rx_valid_r) begin
            target_r   <= {target_r[119:0], rx_sh_r};
            hash_cnt_r <= hash_cnt_r + 4'd1;
            if (hash_cnt_r == 4'd15) begin
              match_r <= 1'b0; ack_r <= 8'h01; state_r <= ST_ACK_TX;
            end
          end
        ST_LEN_HI:
          if (rx_valid_r) begin len_r[15:8] <= rx_sh_r; state_r <= ST_LEN_LO; end
        ST_LEN_LO:
          if (rx_valid_r) begin
            len_r[7:0] <= rx_sh_r;
            window_r <= 152'd0; index_r <= 16'd0; match_r <= 1'b0;
            state_r <= ({len_r[15:8], rx_sh_r} == 16'd0) ? ST_TEXT_DRAIN : ST_TEXT_RX;
          end
        ST_TEXT_RX:
          if (rx_valid_r) begin
            window_r <= {window_r[143:0], rx_sh_r};
            index_r  <= index_r + 16'd1;
            if (index_r == len_r - 16'd1) state_r <= ST_TEXT_DRAIN;
          end
        ST_TEXT_DRAIN:
          if (!md5_busy_r && !md5_done_r) begin
            ack_r <= match_r ? 8'h01 : 8'h00; state_r <= ST_ACK_TX;
          end
        ST_ACK_TX:   if (tx_load_s) state_r <= ST_IDLE;
        ST_MATCH_TX: if (tx_load_s && out_idx_r == 5'd20) state_r <= ST_IDLE;
        ST_TEST_TX:  if (tx_load_s && out_idx_r == 5'd4) state_r <= ST_IDLE;
        default:     state_r <= ST_IDLE;
      endcase
    end
  end

  assign bus.txd       = txd_r;
  assign bus.match_led = match_r;

  generate
    if (NUM_LEDS > 4) begin : g_led_wide
      assign bus.led = {{(NUM_LEDS-4){1'b0}}, state_r};
    end else if (NUM_LEDS == 4) begin : g_led_exact
      assign bus.led = state_r;
    end else begin : g_led_narrow
      assign bus.led = state_r[NUM_LEDS-1:0];
    end
  endgenerate
endmodule

// File: tb/tb_md5_top.sv
`timescale 1ns/1ps
module tb_md5_top;
  localparam int BIT = 8;                 // round(100 MHz / 12 Mbaud)
  localparam time FRAME_NS = 10 * BIT * 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md5_if #(.NUM_LEDS(4)) bus();
  md5_top #(.CLK_FREQUENCY(100_000_000), .BAUD(12_000_000), .NUM_LEDS(4)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;
  int frame_err = 0;
  logic [7:0] rx_q[$];
  time        rx_t[$];
  logic [151:0]  pat;
  logic [127:0]  hash;

  // UART decoder on txd, sampling on the falling clock edge.
  initial begin : monitor
    logic [7:0] b;
    time t0;
    forever begin
      @(negedge bus.txd);
      t0 = $time;
      repeat (BIT / 2) @(negedge clk);
      if (bus.txd == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = bus.txd;
        end
        repeat (BIT) @(negedge clk);
        if (bus.txd == 1'b1) begin rx_q.push_back(b); rx_t.push_back(t0); end
        else frame_err++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    bus.rxd = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic wait_rx(input int n, input int budget, output logic ok);
    int c;
    c = 0;
    while (rx_q.size() < n && c < budget) begin @(negedge clk); c++; end
    ok = (rx_q.size() >= n);
  endtask

  function automatic logic [7:0] pat_byte(input int k);
    return pat[151-8*k -: 8];
  endfunction

  task automatic test_reset;
    bus.rxd = 1'b1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.txd !== 1'b1) begin failures++; $display("FAIL reset_txd got=%b exp=1", bus.txd); end
    checks++; if (bus.match_led !== 1'b0) begin failures++; $display("FAIL reset_match_led got=%b exp=0", bus.match_led); end
    checks++; if (bus.led !== 4'd0) begin failures++; $display("FAIL reset_led got=%0d exp=0", bus.led); end
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (bus.led !== 4'd0 || bus.txd !== 1'b1) begin
      failures++; $display("FAIL post_reset_idle led=%0d txd=%b exp led=0 txd=1", bus.led, bus.txd);
    end
  endtask

  task automatic test_set_hash;
    logic ok;
    rx_q.delete(); rx_t.delete();
    send_byte(8'h01);
    checks++; if (bus.led !== 4'd1) begin failures++; $display("FAIL hash_rx_led got=%0d exp=1", bus.led); end
    for (int i = 0; i < 16; i++) send_byte(hash[127-8*i -: 8]);
    wait_rx(1, 400, ok);
    checks++; if (!ok || rx_q[0] !== 8'h01) begin
      failures++; $display("FAIL set_hash_ack got=%h (rx=%0d) exp=01", ok ? rx_q[0] : 8'hxx, rx_q.size());
    end
    checks++; if (bus.led !== 4'd0) begin failures++; $display("FAIL set_hash_led_idle got=%0d exp=0", bus.led); end
  endtask

  task automatic test_text_match;
    logic ok;
    rx_q.delete(); rx_t.delete();
    send_byte(8'h02);
    checks++; if (bus.led !== 4'd2) begin failures++; $display("FAIL len_hi_led got=%0d exp=2", bus.led); end
    send_byte(8'h00);
    checks++; if (bus.led !== 4'd3) begin failures++; $display("FAIL len_lo_led got=%0d exp=3", bus.led); end
    send_byte(8'hC8);
    checks++; if (bus.led !== 4'd4) begin failures++; $display("FAIL text_rx_led got=%0d exp=4", bus.led); end
    for (int i = 0; i < 200; i++) begin
      if (i >= 100 && i <= 118) send_byte(pat_byte(i - 100));
      else send_byte(8'(i * 7 + 3));
    end
    wait_rx(1, 600, ok);
    checks++; if (!ok || rx_q[0] !== 8'h01) begin
      failures++; $display("FAIL text_match_ack got=%h (rx=%0d) exp=01", ok ? rx_q[0] : 8'hxx, rx_q.size());
    end
    checks++; if (bus.match_led !== 1'b1) begin failures++; $display("FAIL text_match_led got=%b exp=1", bus.match_led); end
  endtask

  task automatic test_read_match;
    logic ok;
    logic [7:0] exp_b;
    int bad_gaps;
    rx_q.delete(); rx_t.delete();
    send_byte(8'h03);
    send_byte(8'h04);                     // arrives during MATCH_TX, must be dropped
    wait_rx(21, 3000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL read_match_count got=%0d exp=21", rx_q.size()); end
    if (ok) begin
      for (int k = 0; k < 21; k++) begin
        exp_b = (k == 0) ? 8'h00 : (k == 1) ? 8'h76 : pat_byte(k - 2);
        checks++;
        if (rx_q[k] !== exp_b) begin
          failures++; $display("FAIL read_match_byte%0d got=%h exp=%h", k, rx_q[k], exp_b);
        end
      end
      bad_gaps = 0;
      for (int k = 1; k < 21; k++) if (rx_t[k] - rx_t[k-1] != FRAME_NS) bad_gaps++;
      checks++; if (bad_gaps != 0) begin failures++; $display("FAIL back_to_back_gaps got=%0d exp=0", bad_gaps); end
    end
    repeat (300) @(negedge clk);
    checks++; if (rx_q.size() != 21) begin failures++; $display("FAIL ignore_during_tx got=%0d exp=21", rx_q.size()); end
    checks++; if (bus.led !== 4'd0) begin failures++; $display("FAIL read_match_led_idle got=%0d exp=0", bus.led); end
  endtask

  task automatic test_no_match;
    logic ok;
    rx_q.delete(); rx_t.delete();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'hC8);
    for (int i = 0; i < 200; i++) send_byte(8'(i) ^ 8'h5A);
    wait_rx(1, 600, ok);
    checks++; if (!ok || rx_q[0] !== 8'h00) begin
      failures++; $display("FAIL no_match_ack got=%h (rx=%0d) exp=00", ok ? rx_q[0] : 8'hxx, rx_q.size());
    end
    checks++; if (bus.match_led !== 1'b0) begin failures++; $display("FAIL no_match_led got=%b exp=0", bus.match_led); end
  endtask

  task automatic test_short_and_test_cmd;
    logic ok;
    rx_q.delete(); rx_t.delete();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h0A);
    for (int i = 0; i < 10; i++) send_byte(pat_byte(i));
    wait_rx(1, 600, ok);
    checks++; if (!ok || rx_q[0] !== 8'h00) begin
      failures++; $display("FAIL short_text_ack got=%h (rx=%0d) exp=00", ok ? rx_q[0] : 8'hxx, rx_q.size());
    end
    rx_q.delete(); rx_t.delete();
    send_byte(8'h04);
    wait_rx(5, 1000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL test_cmd_count got=%0d exp=5", rx_q.size()); end
    if (ok) begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (rx_q[k] !== 8'(5 - k)) begin
          failures++; $display("FAIL test_cmd_byte%0d got=%h exp=%h", k, rx_q[k], 8'(5 - k));
        end
      end
    end
  endtask

  task automatic test_reset_abort;
    logic ok;
    int bad;
    send_byte(8'h01);
    for (int i = 0; i < 5; i++) send_byte(hash[127-8*i -: 8]);
    bus.rxd = 1'b0;                       // reset lands in the middle of a byte
    repeat (3 * BIT) @(negedge clk);
    reset = 1'b0;
    bus.rxd = 1'b1;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.txd !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL reset_txd_idle got=%0d_low_cycles exp=0", bad); end
    checks++; if (bus.led !== 4'd0 || bus.match_led !== 1'b0) begin
      failures++; $display("FAIL reset_abort_state led=%0d match=%b exp led=0 match=0", bus.led, bus.match_led);
    end
    reset = 1'b1;
    repeat (20) @(negedge clk);
    rx_q.delete(); rx_t.delete();
    send_byte(8'h55);                     // unknown opcode
    checks++; if (bus.led !== 4'd0) begin failures++; $display("FAIL unknown_opcode_led got=%0d exp=0", bus.led); end
    send_byte(8'h03);
    wait_rx(21, 3000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL zero_read_count got=%0d exp=21", rx_q.size()); end
    if (ok) begin
      bad = 0;
      for (int k = 0; k < 21; k++) if (rx_q[k] !== 8'h00) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL zero_read_bytes got=%0d_nonzero exp=0", bad); end
    end
    repeat (300) @(negedge clk);
    checks++; if (rx_q.size() != 21) begin failures++; $display("FAIL zero_read_extra got=%0d exp=21", rx_q.size()); end
  endtask

  initial begin
    reset   = 1'b0;
    bus.rxd = 1'b1;
    pat     = "ed alice30.txt or a";
    hash    = 128'h7e2ba776cc7b346f3592bfedb41b18bd;
    test_reset();
    test_set_hash();
    test_text_match();
    test_read_match();
    test_no_match();
    test_short_and_test_cmd();
    test_reset_abort();
    checks++; if (frame_err != 0) begin failures++; $display("FAIL framing got=%0d exp=0", frame_err); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/md5_top.md
MD5_TOP -- requirements
Module: md5_top

Interface
REQ-001 Parameter CLK_FREQUENCY, default 100_000_000, clk frequency in Hz.
REQ-002 Parameter BAUD, default 12_000_000, UART bit rate.
REQ-003 Parameter NUM_LEDS, default 4, width of led.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 rxd  input  1  UART receive line, idle high.
REQ-007 txd  output  1  UART transmit line, idle high.
REQ-008 match_led  output  1  high while a match is latched.
REQ-009 led  output  NUM_LEDS  parser state code, zero-extended or truncated.

Function
REQ-010 UART format SHALL be 8N1, LSB first; bit period = round(CLK_FREQUENCY/BAUD) clocks.
REQ-011 The receiver SHALL confirm the start bit at mid-bit, sample each data bit at mid-bit, and discard a byte whose stop bit is 0.
REQ-012 The transmitter SHALL send queued response bytes back-to-back, with no gaps beyond the stop bit.
REQ-013 Parser states and led codes SHALL be IDLE=0, HASH_RX=1, LEN_HI=2, LEN_LO=3, TEXT_RX=4, TEXT_DRAIN=5, ACK_TX=6, MATCH_TX=7, TEST_TX=8.
REQ-014 In IDLE, opcode 0x01 SHALL go to HASH_RX, 0x02 to LEN_HI, 0x03 to MATCH_TX and 0x04 to TEST_TX; any other byte SHALL be ignored.
REQ-015 SET_HASH (0x01): the next 16 bytes SHALL be stored MSB-first as target_hash[127:0]. The match latch SHALL then be cleared, ack 0x01 sent, and the parser SHALL return to IDLE.
REQ-016 SEND_TEXT (0x02): a 16-bit length N SHALL be received MSB then LSB. The 19-byte window, byte index and match latch SHALL be cleared, then N payload bytes received.
REQ-017 Each payload byte SHALL shift into a 19-byte window (oldest byte = message byte 0). Its 0-based index within the command SHALL be recorded.
REQ-018 When index >= 18, an MD5 (RFC 1321) SHALL be computed over the 19-byte window: single 512-bit block, padding 0x80, bit length 152, little-endian word packing.
REQ-019 MD5 SHALL be iterative at one round per clock: 64 rounds plus at most 6 overhead clocks, finishing before the next byte can arrive.
REQ-020 Digest byte order SHALL be the standard hex digest (A low byte first), compared against target_hash[127:120] first.
REQ-021 On digest equality with no match yet latched, the block SHALL latch match=1, match_pos = index of the window's last byte, and the 19-byte window. Later matches SHALL be ignored.
REQ-022 After byte N-1 the parser SHALL enter TEXT_DRAIN until any pending hash completes, then send ack 0x01 if matched, else 0x00.
REQ-023 N=0 or N<19: no hash SHALL run; ack 0x00.
REQ-024 READ_MATCH (0x03): the block SHALL send 21 bytes: match_pos MSB, match_pos LSB, then the 19 latched bytes oldest first. With no match it SHALL send all zeros.
REQ-025 TEST (0x04): the block SHALL send 0x05, 0x04, 0x03, 0x02, 0x01, then return to IDLE.
REQ-026 Bytes received during ACK_TX, MATCH_TX or TEST_TX SHALL be ignored.
REQ-027 match_led SHALL equal the match latch.

Reset
REQ-028 While reset is low at a clk edge, the block SHALL set:
  - txd=1, match_led=0, led=0, state IDLE;
  - target_hash=0, window=0, index=0, match_pos=0, match latch cleared;
  - UART rx and tx idle, MD5 engine idle.
REQ-029 Reset mid-command or mid-transmission SHALL abort immediately. Release SHALL resume in IDLE with no residual output byte.

Verification
REQ-030 reset low 2 clocks; 0x01 + 7e2ba776cc7b346f3592bfedb41b18bd -> ack 0x01; led returns to 0.
REQ-031 0x02, 0x00, 0xC8, 200 bytes with "ed alice30.txt or a" at offsets 100..118 -> ack 0x01; match_led=1.
REQ-032 Then 0x03 -> 0x00, 0x76, then bytes "ed alice30.txt or a" in order.
REQ-033 0x02 with a 200-byte payload not containing the string -> ack 0x00; match_led=0.
REQ-034 0x02, 0x00, 0x0A, 10 bytes -> ack 0x00; 0x04 -> 05 04 03 02 01.
REQ-035 reset pulsed during the SET_HASH payload; then 0x03 -> 21 zero bytes; txd idle high during reset.
